// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer and collector for an 8:1 mux: walks the selects, samples y per channel and packs one byte per frame.
// Latency: done is high after edge 8*(SETTLE+1), counting the start-accept edge as edge 0.
// Backpressure: none; start is taken only in IDLE and ignored while busy, and cont chains frames with no gap.
module mux8_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic [7:0] frames
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  // The last settle count before sampling. With SETTLE=0 the settle state is never entered.
  localparam logic [3:0] CNT_LAST = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);
  // Each channel starts by settling, unless there is no settle delay at all.
  localparam state_t FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ch;
  logic [3:0] cnt;
  logic [6:0] sh;
  logic       accept;
  logic       take;
  logic       last;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the per-cycle strobes that drive the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take      = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = FIRST_ST;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        take = 1'b1;
        if (ch == 3'd7) begin
          last      = 1'b1;
          // cont only matters here, on the final sample of a frame.
          state_nxt = cont ? FIRST_ST : ST_IDLE;
        end else begin
          state_nxt = FIRST_ST;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Channel walk, settle counting, shadow capture and frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch     <= 3'd0;
      cnt    <= 4'd0;
      sh     <= 7'd0;
      data   <= 8'd0;
      done   <= 1'b0;
      frames <= 8'd0;
    end else begin
      done <= last;
      if (accept) begin
        ch  <= 3'd0;
        cnt <= 4'd0;
      end
      if (state == ST_SETTLE) begin
        cnt <= cnt + 4'd1;
      end
      if (take) begin
        // Channel 7 goes straight into data, so only channels 0..6 need shadowing.
        for (int k = 0; k < 7; k++) begin
          if (ch == 3'(k)) begin
            sh[k] <= y;
          end
        end
        cnt <= 4'd0;
        // Wrapping 7 -> 0 also leaves the select at channel 0 for IDLE or the next frame.
        ch  <= ch + 3'd1;
      end
      if (last) begin
        // data is only ever replaced whole, on frame completion.
        data   <= {y, sh};
        frames <= frames + 8'd1;
      end
    end
  end

  // Select lines come straight from the channel register; s0 is the MSB.
  assign {s0, s1, s2} = ch;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
module tb_mux8_scan_ctrl;

  typedef struct {
    int         exp_cycle;
    logic [7:0] data;
    logic [7:0] frames;
  } exp_t;

  logic       clk;
  logic [7:0] mux_in;

  // DUT with SETTLE=1 (index 1) and SETTLE=0 (index 0) share the mux data inputs.
  logic       rst1, start1, cont1, y1;
  logic       d1_s0, d1_s1, d1_s2, d1_busy, d1_done;
  logic [7:0] d1_data, d1_frames;
  logic       rst0, start0, cont0, y0;
  logic       d0_s0, d0_s1, d0_s2, d0_busy, d0_done;
  logic [7:0] d0_data, d0_frames;

  assign y1 = mux_in[{d1_s0, d1_s1, d1_s2}];
  assign y0 = mux_in[{d0_s0, d0_s1, d0_s2}];

  mux8_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .cont(cont1), .y(y1),
    .s0(d1_s0), .s1(d1_s1), .s2(d1_s2), .busy(d1_busy), .done(d1_done),
    .data(d1_data), .frames(d1_frames)
  );

  mux8_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .cont(cont0), .y(y0),
    .s0(d0_s0), .s1(d0_s1), .s2(d0_s2), .busy(d0_busy), .done(d0_done),
    .data(d0_data), .frames(d0_frames)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state per DUT: frame in flight, accept edge, collected bits, outputs.
  logic       m_busy   [2];
  int         m_acc    [2];
  logic [7:0] m_sh     [2];
  logic [7:0] m_data   [2];
  logic [7:0] m_frames [2];
  exp_t       q0[$];
  exp_t       q1[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input int id, input int s);
    exp_t e;
    m_busy[id]  = 1'b1;
    m_acc[id]   = cyc;
    e.exp_cycle = cyc + 8 * (s + 1);
    e.data      = 8'd0;
    e.frames    = 8'd0;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Frame timing in plain arithmetic: channel k is captured on edge acc + (k+1)*(s+1).
  task automatic model_step(input int id, input int s, input logic r, input logic st, input logic ct);
    int rel;
    int k;
    if (r) begin
      m_busy[id]   = 1'b0;
      m_data[id]   = 8'd0;
      m_frames[id] = 8'd0;
      if (id == 0) q0.delete();
      else         q1.delete();
    end else if (m_busy[id]) begin
      rel = cyc - m_acc[id];
      if (rel % (s + 1) == 0) begin
        k = rel / (s + 1) - 1;
        m_sh[id][k] = mux_in[k];
        if (k == 7) begin
          m_data[id]   = m_sh[id];
          m_frames[id] = m_frames[id] + 8'd1;
          if (id == 0 && q0.size() > 0) begin
            q0[q0.size()-1].data   = m_data[id];
            q0[q0.size()-1].frames = m_frames[id];
          end
          if (id == 1 && q1.size() > 0) begin
            q1[q1.size()-1].data   = m_data[id];
            q1[q1.size()-1].frames = m_frames[id];
          end
          if (ct) model_accept(id, s);
          else    m_busy[id] = 1'b0;
        end
      end
    end else if (st) begin
      model_accept(id, s);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, 0, rst0, start0, cont0);
    model_step(1, 1, rst1, start1, cont1);
  end

  // Monitor: compares visible state every cycle and pops the scoreboard on done.
  task automatic mon(input int id, input int s, input logic bz, input logic [2:0] sel,
                     input logic dn, input logic [7:0] dt, input logic [7:0] fr);
    exp_t e;
    int   qs;
    int   ex_sel;
    string p;
    p      = (id == 0) ? "s0dut" : "s1dut";
    ex_sel = m_busy[id] ? ((cyc - m_acc[id]) / (s + 1)) : 0;
    chk({p, "_busy"}, int'(bz), int'(m_busy[id]));
    chk({p, "_sel"}, int'(sel), ex_sel);
    chk({p, "_data_hold"}, int'(dt), int'(m_data[id]));
    chk({p, "_frames"}, int'(fr), int'(m_frames[id]));
    qs = (id == 0) ? q0.size() : q1.size();
    if (dn) begin
      if (qs == 0) begin
        chk({p, "_done_unexpected"}, 1, 0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk({p, "_done_cycle"}, cyc, e.exp_cycle);
        chk({p, "_done_data"}, int'(dt), int'(e.data));
        chk({p, "_done_frames"}, int'(fr), int'(e.frames));
      end
    end else if (qs > 0) begin
      e = (id == 0) ? q0[0] : q1[0];
      if (e.exp_cycle <= cyc) begin
        chk({p, "_done_missing"}, 0, 1);
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 0, d0_busy, {d0_s0, d0_s1, d0_s2}, d0_done, d0_data, d0_frames);
    mon(1, 1, d1_busy, {d1_s0, d1_s1, d1_s2}, d1_done, d1_data, d1_frames);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b1; start1 = 1'b1;
    cont0 = 1'b0; cont1 = 1'b0; mux_in = 8'h00;

    // Reset held two cycles with start asserted.
    repeat (2) tick();
    rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) tick();

    // Single frame, SETTLE=1.
    mux_in = 8'hA6;
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (20) tick();

    // Continuous mode; new inputs once the first frame is done.
    cont1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (d1_done) seen = 1'b1;
    end
    if (!seen) chk("t3_first_done_seen", 0, 1);
    mux_in = 8'h3C;
    cont1  = 1'b0;
    repeat (20) tick();

    // Start again while busy.
    mux_in = 8'h5A;
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (4) tick();
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (20) tick();

    // Reset on the SAMPLE cycle of channel 4.
    mux_in = 8'hC3;
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (9) tick();
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    repeat (5) tick();

    // SETTLE=0 build, all ones, more than 256 chained frames.
    mux_in = 8'hFF;
    cont0  = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (257 * 8) tick();
    cont0 = 1'b0;
    repeat (12) tick();

    // Randomized inputs, starts, cont and occasional resets on both builds.
    for (int i = 0; i < 800; i++) begin
      mux_in = 8'($urandom);
      start0 = ($urandom_range(0, 3) == 0);
      start1 = ($urandom_range(0, 3) == 0);
      cont0  = 1'($urandom);
      cont1  = 1'($urandom);
      rst0   = ($urandom_range(0, 60) == 0);
      rst1   = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    cont0 = 1'b0; cont1 = 1'b0;
    repeat (40) tick();

    chk("s0dut_queue_drained", q0.size(), 0);
    chk("s1dut_queue_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
